vigna_bus_arbiter: RTL and testbench
====================================

Name: vigna_bus_arbiter

Overview:
- Sits directly downstream of the vigna core.
- Merges the core's instruction port (i_*) and data port (d_*) onto one shared memory bus (m_*) using the same valid/ready protocol.
- Grants one master at a time. In-flight requests are never pre-empted.
- An optional watchdog completes stalled transactions with an error.

Parameters:
- DATA_PRIORITY, 1: 1 = data port wins simultaneous requests; 0 = round-robin (the port not granted last wins).
- TIMEOUT_CYCLES, 0: cycles a granted transaction may wait for m_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'h0000_0013: read data returned on timeout (RV32I NOP).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  instruction request.
- i_ready  output  1  instruction completion, one-cycle pulse.
- i_addr  input  32  instruction address.
- i_rdata  output  32  instruction read data.
- d_valid  input  1  data request.
- d_ready  output  1  data completion, one-cycle pulse.
- d_addr  input  32  data address.
- d_rdata  output  32  data read data.
- d_wdata  input  32  data write data.
- d_wstrb  input  4  byte strobes; 0 = read.
- m_valid  output  1  shared bus request.
- m_ready  input  1  shared bus completion.
- m_addr  output  32  shared bus address.
- m_rdata  input  32  shared bus read data.
- m_wdata  output  32  shared bus write data.
- m_wstrb  output  4  shared bus strobes.
- grant  output  2  registered owner: 00 none, 01 instr, 10 data.
- bus_err  output  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset state: state=IDLE, grant=00, last=instr, timer=0, bus_err=0. Combinationally this gives m_valid=0, i_ready=0, d_ready=0, m_addr=0, m_wdata=0, m_wstrb=0.
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only i_valid: go to GNT_I.
  - Only d_valid: go to GNT_D.
  - Both: DATA_PRIORITY=1 goes to GNT_D. DATA_PRIORITY=0 goes to the port opposite to `last`.
  - Neither: stay in IDLE.
  - Arbitration costs exactly one cycle. m_valid is first high the cycle after the request is seen in IDLE.
- Bus muxing (combinational from registered state):
  - m_valid = granted master's valid.
  - m_addr = granted master's address.
  - GNT_D: m_wdata = d_wdata, m_wstrb = d_wstrb.
  - GNT_I: m_wdata = 0, m_wstrb = 0.
  - IDLE: all m_* outputs are 0.
- Ready routing:
  - i_ready = m_ready & (state==GNT_I).
  - d_ready = m_ready & (state==GNT_D).
  - A ready is never asserted to the non-granted port.
- Read data: i_rdata = d_rdata = m_rdata, except during a timeout completion cycle (see Watchdog).
- Completion: when m_ready is seen in GNT_x, set last <= x and return to IDLE. A new grant needs one IDLE cycle, so the minimum spacing is 1 bus cycle + 1 arbitration cycle. A master whose valid is still high in that IDLE cycle is re-arbitrated normally.
- Abandoned request: if the granted master's valid drops before m_ready (protocol violation), return to IDLE next cycle, with no ready pulse and no bus_err. m_valid follows valid, so it is already 0 that cycle.
- Holding: the grant is held until completion. The other master's valid is ignored, not queued; it stays pending on its own valid.
- Watchdog (TIMEOUT_CYCLES>0):
  - timer clears on entering GNT_x and increments each GNT_x cycle without m_ready.
  - When timer == TIMEOUT_CYCLES-1 and m_ready=0: that cycle assert the granted port's ready, drive its rdata = ERR_RDATA, and pulse bus_err; then go to IDLE.
  - m_ready arriving in the same cycle as the timeout takes precedence: normal completion, no bus_err.
  - timer width is $clog2(TIMEOUT_CYCLES+1). The timer does not wrap.
- Reset mid-transaction: forces IDLE immediately. The outstanding bus transaction is dropped, and no ready is returned to either port.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x0000_0100; m_ready is pulsed 2 cycles after m_valid rises, with m_rdata=0x0000_0093 -> grant=01, m_addr=0x100, m_wstrb=0; i_ready is one pulse carrying i_rdata=0x93; d_ready stays 0.
- Simultaneous requests, DATA_PRIORITY=1: i_valid and d_valid rise together; d_addr=0x2000, d_wstrb=4'b1111, d_wdata=0xDEADBEEF -> the data write is served first (m_wdata=0xDEADBEEF), then one IDLE cycle, then the fetch is granted.
- Round-robin, DATA_PRIORITY=0: both requesters are held continuously valid with immediate m_ready -> the grant sequence alternates 01,10,01,10.
- Timeout, TIMEOUT_CYCLES=4: d_valid read at 0x3000 with m_ready held 0 -> on the 4th GNT_D cycle, d_ready=1, d_rdata=0x13, bus_err=1; returns to IDLE.
- Timeout race: m_ready arrives in the exact timeout cycle -> d_rdata=m_rdata and bus_err=0.
- Reset mid-grant: assert reset during GNT_I before m_ready -> next cycle grant=00 and m_valid=0; no i_ready pulse observed.

Source files
------------

// File: rtl/vigna_bus_arbiter.sv
// Two-master arbiter merging the vigna instruction and data ports onto one
// shared valid/ready memory bus, with an optional stall watchdog.
module vigna_bus_arbiter #(
    parameter int unsigned DATA_PRIORITY  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic [1:0]  grant,
    output logic        bus_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_d;
    logic          last_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          own_valid;
    logic          timeout;

    // Granted master still requesting, and watchdog expiry for this cycle
    assign own_valid = ((state == GNT_I) && i_valid) || ((state == GNT_D) && d_valid);
    assign timeout   = (TIMEOUT_CYCLES != 0) && own_valid && !m_ready && (timer == T_LAST);

    // State register; grant is the registered state encoding
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
            timer  <= '0;
        end else begin
            state  <= state_nxt;
            last_d <= last_nxt;
            timer  <= timer_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, hold grant until completion or abandon
    always_comb begin
        state_nxt = state;
        last_nxt  = last_d;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (i_valid && d_valid) begin
                    state_nxt = ((DATA_PRIORITY != 0) || !last_d) ? GNT_D : GNT_I;
                end else if (i_valid) begin
                    state_nxt = GNT_I;
                end else if (d_valid) begin
                    state_nxt = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ready || timeout) begin
                    state_nxt = IDLE;
                    last_nxt  = (state == GNT_D);
                end else if (!own_valid) begin
                    state_nxt = IDLE;
                end else if (timer != T_MAX) begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output mux; readies are withheld while reset is asserted
    always_comb begin
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        bus_err = 1'b0;
        grant   = state;
        i_rdata = (timeout && (state == GNT_I)) ? ERR_RDATA : m_rdata;
        d_rdata = (timeout && (state == GNT_D)) ? ERR_RDATA : m_rdata;
        case (state)
            GNT_I: begin
                m_valid = i_valid;
                m_addr  = i_addr;
                i_ready = (m_ready || timeout) && !reset;
                bus_err = timeout && !reset;
            end
            GNT_D: begin
                m_valid = d_valid;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
                d_ready = (m_ready || timeout) && !reset;
                bus_err = timeout && !reset;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Bench for vigna_bus_arbiter: three configurations (data priority, round-robin,
// watchdog of 4) share stimulus and are checked every cycle against a transaction model.
module tb_vigna_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, d_valid, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_wstrb;

    logic        o_i_ready [3];
    logic        o_d_ready [3];
    logic        o_m_valid [3];
    logic        o_bus_err [3];
    logic [31:0] o_i_rdata [3];
    logic [31:0] o_d_rdata [3];
    logic [31:0] o_m_addr  [3];
    logic [31:0] o_m_wdata [3];
    logic [3:0]  o_m_wstrb [3];
    logic [1:0]  o_grant   [3];

    int total = 0;
    int bad   = 0;

    // Model: owner 0 none / 1 instr / 2 data, last 0 instr / 1 data, gcyc = grant cycle number
    int owner [3];
    int last  [3];
    int gcyc  [3];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            vigna_bus_arbiter #(
                .DATA_PRIORITY  ((g == 1) ? 0 : 1),
                .TIMEOUT_CYCLES ((g == 2) ? 4 : 0),
                .ERR_RDATA      (32'h0000_0013)
            ) u_dut (
                .clk     (clk),
                .reset   (reset),
                .i_valid (i_valid),
                .i_ready (o_i_ready[g]),
                .i_addr  (i_addr),
                .i_rdata (o_i_rdata[g]),
                .d_valid (d_valid),
                .d_ready (o_d_ready[g]),
                .d_addr  (d_addr),
                .d_rdata (o_d_rdata[g]),
                .d_wdata (d_wdata),
                .d_wstrb (d_wstrb),
                .m_valid (o_m_valid[g]),
                .m_ready (m_ready),
                .m_addr  (o_m_addr[g]),
                .m_rdata (m_rdata),
                .m_wdata (o_m_wdata[g]),
                .m_wstrb (o_m_wstrb[g]),
                .grant   (o_grant[g]),
                .bus_err (o_bus_err[g])
            );
        end
    endgenerate

    function automatic int dp_of(int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int to_of(int k);
        return (k == 2) ? 4 : 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model to the next edge
    always @(negedge clk) begin : cmp
        logic        own_v;
        logic        tmo;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        for (int k = 0; k < 3; k++) begin
            own_v   = (owner[k] == 1) ? i_valid : (owner[k] == 2) ? d_valid : 1'b0;
            tmo     = (to_of(k) > 0) && (owner[k] != 0) && own_v && !m_ready && (gcyc[k] == to_of(k));
            e_addr  = (owner[k] == 1) ? i_addr : (owner[k] == 2) ? d_addr : 32'h0;
            e_wdata = (owner[k] == 2) ? d_wdata : 32'h0;
            e_wstrb = (owner[k] == 2) ? d_wstrb : 4'h0;
            check($sformatf("u%0d grant", k),   32'(o_grant[k]),   32'(owner[k]));
            check($sformatf("u%0d m_valid", k), 32'(o_m_valid[k]), 32'(own_v));
            check($sformatf("u%0d m_addr", k),  o_m_addr[k],       e_addr);
            check($sformatf("u%0d m_wdata", k), o_m_wdata[k],      e_wdata);
            check($sformatf("u%0d m_wstrb", k), 32'(o_m_wstrb[k]), 32'(e_wstrb));
            check($sformatf("u%0d i_ready", k), 32'(o_i_ready[k]),
                  32'(!reset && owner[k] == 1 && (m_ready || tmo)));
            check($sformatf("u%0d d_ready", k), 32'(o_d_ready[k]),
                  32'(!reset && owner[k] == 2 && (m_ready || tmo)));
            check($sformatf("u%0d i_rdata", k), o_i_rdata[k],
                  (tmo && owner[k] == 1) ? 32'h0000_0013 : m_rdata);
            check($sformatf("u%0d d_rdata", k), o_d_rdata[k],
                  (tmo && owner[k] == 2) ? 32'h0000_0013 : m_rdata);
            check($sformatf("u%0d bus_err", k), 32'(o_bus_err[k]), 32'(!reset && tmo));

            if (reset) begin
                owner[k] = 0;
                last[k]  = 0;
                gcyc[k]  = 0;
            end else if (owner[k] == 0) begin
                if (i_valid && d_valid) owner[k] = (dp_of(k) != 0 || last[k] == 0) ? 2 : 1;
                else if (i_valid)       owner[k] = 1;
                else if (d_valid)       owner[k] = 2;
                gcyc[k] = 1;
            end else if (m_ready || tmo) begin
                last[k]  = owner[k] - 1;
                owner[k] = 0;
            end else if (!own_v) begin
                owner[k] = 0;
            end else begin
                gcyc[k]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0;
        i_addr  = '0;   d_addr  = '0;   d_wdata = '0;
        d_wstrb = '0;   m_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    logic [1:0] rr_seq [$];

    initial begin
        for (int k = 0; k < 3; k++) begin
            owner[k] = 0; last[k] = 0; gcyc[k] = 0;
        end
        reset = 1'b1;
        idle_inputs();

        // Single fetch on the data-priority instance
        do_reset();
        i_valid = 1'b1; i_addr = 32'h0000_0100;
        @(negedge clk);
        check("reset grant", 32'(o_grant[0]), 32'h0);
        check("reset m_valid", 32'(o_m_valid[0]), 32'h0);
        check("reset bus_err", 32'(o_bus_err[0]), 32'h0);
        step();
        @(negedge clk);
        check("fetch grant", 32'(o_grant[0]), 32'h1);
        check("fetch m_addr", o_m_addr[0], 32'h0000_0100);
        check("fetch m_wstrb", 32'(o_m_wstrb[0]), 32'h0);
        step();
        @(negedge clk);
        check("fetch early i_ready", 32'(o_i_ready[0]), 32'h0);
        step();
        m_ready = 1'b1; m_rdata = 32'h0000_0093;
        @(negedge clk);
        check("fetch i_ready", 32'(o_i_ready[0]), 32'h1);
        check("fetch i_rdata", o_i_rdata[0], 32'h0000_0093);
        check("fetch d_ready", 32'(o_d_ready[0]), 32'h0);
        step();
        m_ready = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        check("fetch pulse end", 32'(o_i_ready[0]), 32'h0);
        check("fetch back idle", 32'(o_grant[0]), 32'h0);

        // Simultaneous requests with data priority
        do_reset();
        i_valid = 1'b1; i_addr = 32'h0000_0100;
        d_valid = 1'b1; d_addr = 32'h0000_2000; d_wstrb = 4'hF; d_wdata = 32'hDEAD_BEEF;
        step();
        m_ready = 1'b1;
        @(negedge clk);
        check("prio grant data", 32'(o_grant[0]), 32'h2);
        check("prio m_wdata", o_m_wdata[0], 32'hDEAD_BEEF);
        check("prio m_addr", o_m_addr[0], 32'h0000_2000);
        check("prio d_ready", 32'(o_d_ready[0]), 32'h1);
        check("prio no i_ready", 32'(o_i_ready[0]), 32'h0);
        step();
        d_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        check("prio gap idle", 32'(o_grant[0]), 32'h0);
        step();
        m_ready = 1'b1;
        @(negedge clk);
        check("prio then instr", 32'(o_grant[0]), 32'h1);
        check("prio instr wdata", o_m_wdata[0], 32'h0);
        check("prio instr ready", 32'(o_i_ready[0]), 32'h1);
        step();
        idle_inputs();

        // Round-robin: data served once first so instruction wins next
        do_reset();
        d_valid = 1'b1; m_ready = 1'b1;
        step();
        i_valid = 1'b1;
        step();
        rr_seq.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_grant[1] != 2'b00) rr_seq.push_back(o_grant[1]);
            step();
        end
        check("rr count", 32'(rr_seq.size() >= 4), 32'h1);
        if (rr_seq.size() >= 4) begin
            check("rr 0", 32'(rr_seq[0]), 32'h1);
            check("rr 1", 32'(rr_seq[1]), 32'h2);
            check("rr 2", 32'(rr_seq[2]), 32'h1);
            check("rr 3", 32'(rr_seq[3]), 32'h2);
        end
        idle_inputs();

        // Watchdog timeout on a stalled data read
        do_reset();
        d_valid = 1'b1; d_addr = 32'h0000_3000;
        step();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c < 4) begin
                check($sformatf("tmo wait%0d d_ready", c), 32'(o_d_ready[2]), 32'h0);
                check($sformatf("tmo wait%0d bus_err", c), 32'(o_bus_err[2]), 32'h0);
                step();
            end else begin
                check("tmo d_ready", 32'(o_d_ready[2]), 32'h1);
                check("tmo d_rdata", o_d_rdata[2], 32'h0000_0013);
                check("tmo bus_err", 32'(o_bus_err[2]), 32'h1);
            end
        end
        step();
        d_valid = 1'b0;
        @(negedge clk);
        check("tmo back idle", 32'(o_grant[2]), 32'h0);
        check("tmo err pulse", 32'(o_bus_err[2]), 32'h0);

        // m_ready in the exact timeout cycle wins
        do_reset();
        d_valid = 1'b1; d_addr = 32'h0000_3000; m_rdata = 32'hCAFE_0001;
        step();
        step();
        step();
        step();
        m_ready = 1'b1;
        @(negedge clk);
        check("race d_ready", 32'(o_d_ready[2]), 32'h1);
        check("race d_rdata", o_d_rdata[2], 32'hCAFE_0001);
        check("race bus_err", 32'(o_bus_err[2]), 32'h0);
        step();
        idle_inputs();

        // Reset asserted mid-grant
        do_reset();
        i_valid = 1'b1; i_addr = 32'h0000_0040;
        step();
        @(negedge clk);
        check("rst pre grant", 32'(o_grant[0]), 32'h1);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rst i_ready", 32'(o_i_ready[0]), 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst grant", 32'(o_grant[0]), 32'h0);
        check("rst m_valid", 32'(o_m_valid[0]), 32'h0);
        check("rst no ready", 32'(o_i_ready[0]), 32'h0);
        step();
        idle_inputs();

        // Randomized traffic, including abandons and occasional resets
        for (int c = 0; c < 4000; c++) begin
            i_valid = i_valid ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            d_valid = d_valid ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            m_ready = ($urandom_range(0, 2) == 0);
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(0, 15));
            m_rdata = $urandom;
            reset   = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
